// File: rtl/freq_meter_if.sv
// Measurement-side bundle of freq_meter: stimulus inputs plus the reported result.
// The master drives sig_in/enable; the slave (the meter) returns the result signals.
interface freq_meter_if #(
    parameter int CNT_W = 8
);
    logic             sig_in;
    logic             enable;
    logic [CNT_W-1:0] count;
    logic             count_valid;
    logic             overflow;
    logic             busy;

    modport master (
        output sig_in,
        output enable,
        input  count,
        input  count_valid,
        input  overflow,
        input  busy
    );

    modport slave (
        input  sig_in,
        input  enable,
        output count,
        output count_valid,
        output overflow,
        output busy
    );
endinterface

// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronised rising edges of sig_in over a window of
// 2**GATE_W clk cycles and reports a saturating count plus a sticky overflow flag.
module freq_meter #(
    parameter int GATE_W      = 8,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    freq_meter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    localparam logic [GATE_W-1:0] GATE_LAST = {GATE_W{1'b1}};
    localparam logic [GATE_W-1:0] GATE_ONE  = {{(GATE_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic                   w_edge;
    logic [GATE_W-1:0]      r_gate;
    logic [CNT_W-1:0]       r_edge_cnt;
    logic                   r_win_ovf;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_ovf_nxt;
    logic                   w_report;
    logic [CNT_W-1:0]       r_count;
    logic                   r_count_valid;
    logic                   r_overflow;
    logic                   r_busy;

    // Synchroniser chain and edge-detect register run in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], bus.sig_in};
            r_sync_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_sync_prev;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; dropping enable in any MEASURE cycle, including the last, aborts.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.enable) begin
                    w_state_nxt = ST_MEASURE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                if (!bus.enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_gate == GATE_LAST) begin
                    w_state_nxt = ST_REPORT;
                end else begin
                    w_state_nxt = ST_MEASURE;
                end
            end
            ST_REPORT: begin
                if (bus.enable) begin
                    w_state_nxt = ST_MEASURE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_report = (r_state == ST_MEASURE) && bus.enable && (r_gate == GATE_LAST);

    // Saturating edge count; an edge at saturation only raises the sticky overflow.
    always_comb begin
        w_cnt_nxt = r_edge_cnt;
        w_ovf_nxt = r_win_ovf;
        if (w_edge) begin
            if (r_edge_cnt == CNT_MAX) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_edge_cnt + CNT_ONE;
            end
        end else begin
            w_cnt_nxt = r_edge_cnt;
        end
    end

    // Window counters advance only in MEASURE and are held at zero otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gate     <= '0;
            r_edge_cnt <= '0;
            r_win_ovf  <= 1'b0;
        end else if (r_state == ST_MEASURE) begin
            r_gate     <= r_gate + GATE_ONE;
            r_edge_cnt <= w_cnt_nxt;
            r_win_ovf  <= w_ovf_nxt;
        end else begin
            r_gate     <= '0;
            r_edge_cnt <= '0;
            r_win_ovf  <= 1'b0;
        end
    end

    // Result registers: loaded on entry to REPORT (last edge included), held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_count_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_count_valid <= w_report;
            r_busy        <= (w_state_nxt == ST_MEASURE);
            if (w_report) begin
                r_count    <= w_cnt_nxt;
                r_overflow <= w_ovf_nxt;
            end else begin
                r_count    <= r_count;
                r_overflow <= r_overflow;
            end
        end
    end

    assign bus.count       = r_count;
    assign bus.count_valid = r_count_valid;
    assign bus.overflow    = r_overflow;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (256- and 1024-cycle gates) share one stimulus and
// are compared every cycle against a window-level edge-total reference, plus directed checks.
module tb_freq_meter;

    localparam int S    = 2;
    localparam int CMAX = 255;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic sig   = 1'b0;
    logic en    = 1'b0;

    always #5 clk = ~clk;

    freq_meter_if #(.CNT_W(8)) if0 ();
    freq_meter_if #(.CNT_W(8)) if1 ();

    assign if0.sig_in = sig;
    assign if0.enable = en;
    assign if1.sig_in = sig;
    assign if1.enable = en;

    freq_meter #(.GATE_W(8), .CNT_W(8), .SYNC_STAGES(S)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    freq_meter #(.GATE_W(10), .CNT_W(8), .SYNC_STAGES(S)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference: 0 idle, 1 window open, 2 report cycle
    int   ph   [2];
    int   k    [2];
    int   sum  [2];
    int   ecnt [2];
    int   eovf [2];
    int   nrep [2];
    int   win  [2] = '{256, 1024};
    logic [S:0] sh;

    bit periodic = 1'b0;
    int per = 4;
    int hi_len = 2;
    int pc = 0;
    int en_off = 0;
    bit rand_en = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            ph[i]   = 0;
            k[i]    = 0;
            sum[i]  = 0;
            ecnt[i] = 0;
            eovf[i] = 0;
        end
        sh = '0;
    endfunction

    // Edge seen at this posedge is the rising transition sampled S posedges earlier.
    function automatic void model_update();
        logic e;
        if (reset) begin
            model_reset();
        end else begin
            e = sh[S-1] & ~sh[S];
            for (int i = 0; i < 2; i++) begin
                case (ph[i])
                    0: if (en) begin ph[i] = 1; k[i] = 0; sum[i] = 0; end
                    1: begin
                        if (!en) begin
                            ph[i] = 0;
                        end else begin
                            sum[i] += int'(e);
                            if (k[i] == win[i] - 1) begin
                                ph[i]   = 2;
                                ecnt[i] = (sum[i] > CMAX) ? CMAX : sum[i];
                                eovf[i] = (sum[i] > CMAX) ? 1 : 0;
                                nrep[i]++;
                            end else begin
                                k[i]++;
                            end
                        end
                    end
                    default: begin
                        if (en) begin ph[i] = 1; k[i] = 0; sum[i] = 0; end
                        else ph[i] = 0;
                    end
                endcase
            end
            sh = {sh[S-1:0], sig};
        end
    endfunction

    task automatic check_inst(input int i, input logic v, input logic b, input logic o,
                              input logic [7:0] c);
        check_val($sformatf("valid%0d", i), v, (ph[i] == 2));
        check_val($sformatf("busy%0d", i),  b, (ph[i] == 1));
        check_val($sformatf("ovf%0d", i),   o, eovf[i]);
        check_val($sformatf("count%0d", i), c, ecnt[i]);
    endtask

    task automatic drive();
        if (periodic) begin
            sig = ((pc % per) < hi_len);
            pc++;
        end
        if (rand_en) begin
            if (en_off > 0) begin
                en = 1'b0;
                en_off--;
            end else begin
                en = 1'b1;
                if ($urandom_range(0, 299) == 0) en_off = $urandom_range(1, 40);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_inst(0, if0.count_valid, if0.busy, if0.overflow, if0.count);
        check_inst(1, if1.count_valid, if1.busy, if1.overflow, if1.count);
        @(negedge clk);
        drive();
    endtask

    task automatic wait_reports(input int i, input int n, input int budget);
        int target;
        int c;
        target = nrep[i] + n;
        c = 0;
        while (nrep[i] < target && c < budget) begin
            step();
            c++;
        end
        check_val($sformatf("report_timeout%0d", i), (nrep[i] >= target), 1);
    endtask

    task automatic set_period(input int p, input int h);
        periodic = 1'b1;
        per = p;
        hi_len = h;
    endtask

    initial begin
        int gap;
        nrep = '{0, 0};
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_inst(0, if0.count_valid, if0.busy, if0.overflow, if0.count);
        check_inst(1, if1.count_valid, if1.busy, if1.overflow, if1.count);
        reset = 1'b0;
        en = 1'b1;
        set_period(4, 2);

        // period 4: 64 edges per 256-cycle gate, 256 edges saturate the 1024-cycle gate
        wait_reports(0, 2, 1000);
        check_val("p4_count", if0.count, 64);
        check_val("p4_ovf", if0.overflow, 0);
        gap = 0;
        do begin step(); gap++; end while (!if0.count_valid && gap < 600);
        check_val("report_period", gap, 257);
        wait_reports(1, 2, 3000);
        check_val("p4_count_long", if1.count, 255);
        check_val("p4_ovf_long", if1.overflow, 1);

        set_period(32, 16);
        wait_reports(0, 2, 1000);
        check_val("p32_count", if0.count, 8);
        set_period(8, 4);
        wait_reports(0, 2, 1000);
        check_val("p8_count", if0.count, 32);

        set_period(2, 1);
        wait_reports(1, 2, 3000);
        check_val("p2_count_long", if1.count, 255);
        check_val("p2_ovf_long", if1.overflow, 1);
        check_val("p2_count", if0.count, 128);
        set_period(32, 16);
        wait_reports(1, 2, 3000);
        check_val("p32_count_long", if1.count, 32);
        check_val("p32_ovf_long", if1.overflow, 0);

        periodic = 1'b0;
        sig = 1'b0;
        wait_reports(0, 2, 1000);
        check_val("hold0_count", if0.count, 0);
        sig = 1'b1;
        wait_reports(0, 2, 1000);
        check_val("hold1_count", if0.count, 0);
        sig = 1'b0;
        wait_reports(0, 2, 1000);
        repeat (60) step();
        #2 sig = 1'b1;
        wait_reports(0, 1, 1000);
        check_val("step_count", if0.count, 1);

        // abort after 100 MEASURE cycles keeps the previous result
        set_period(8, 4);
        wait_reports(0, 2, 1000);
        repeat (100) step();
        en = 1'b0;
        step();
        check_val("abort_busy", if0.busy, 0);
        check_val("abort_valid", if0.count_valid, 0);
        repeat (5) step();
        check_val("abort_hold", if0.count, 32);
        en = 1'b1;
        wait_reports(0, 1, 1000);
        check_val("reenable_count", if0.count, 32);

        // asynchronous reset mid-window, then first-result latency
        repeat (50) step();
        reset = 1'b1;
        model_reset();
        #1;
        check_val("rst_count", if0.count, 0);
        check_val("rst_busy", if0.busy, 0);
        check_val("rst_valid", if0.count_valid, 0);
        check_val("rst_ovf", if1.overflow, 0);
        repeat (3) step();
        reset = 1'b0;
        gap = 0;
        do begin step(); gap++; end while (!if0.count_valid && gap < 600);
        check_val("first_latency", gap, 257);

        // randomized periods, duty cycles and enable drops
        rand_en = 1'b1;
        for (int seg = 0; seg < 8; seg++) begin
            per = $urandom_range(2, 48);
            hi_len = $urandom_range(1, per - 1);
            periodic = 1'b1;
            repeat (700) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
